// File: rtl/arbitro_rr_mux2x1_if.sv
// Request/grant bundle between two requesters and the round-robin arbiter.
// Carries the level requests in and the registered gnt/S/valid outputs back.
// master = requester side (drives req), slave = arbiter side (drives gnt/S/valid).
interface arbitro_rr_mux2x1_if;
    logic [1:0] req;    // req[0] wants i0, req[1] wants i1
    logic [1:0] gnt;    // one-hot or zero grant
    logic       S;      // mux select, follows the granted index
    logic       valid;  // any grant active

    modport master (
        output req,
        input  gnt,
        input  S,
        input  valid
    );

    modport slave (
        input  req,
        output gnt,
        output S,
        output valid
    );
endinterface

// File: rtl/arbitro_rr_mux2x1.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux stage.
// Latency: one cycle from sampled req to registered gnt/S/valid.
// Backpressure: a source holding the grant while the other waits is preempted after MAX_HOLD cycles.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave modport of arbitro_rr_mux2x1_if (req in; gnt, S, valid out)
module arbitro_rr_mux2x1 #(
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    arbitro_rr_mux2x1_if.slave     bus
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [1:0]      gnt_q;
    logic            s_q;
    logic            valid_q;

    assign bus.gnt   = gnt_q;
    assign bus.S     = s_q;
    assign bus.valid = valid_q;

    // Grant decision for the coming edge.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.req == 2'b01)
                    nxt = G0;
                else if (bus.req == 2'b10)
                    nxt = G1;
                else if (bus.req == 2'b11)
                    nxt = last ? G0 : G1;   // tie goes to the source not served last
                else
                    nxt = IDLE;
            end
            G0: begin
                if (!bus.req[0])
                    nxt = bus.req[1] ? G1 : IDLE;
                else if (bus.req[1] && (cnt == CNT_MAX))
                    nxt = G1;               // hold budget spent while i1 waits
                else
                    nxt = G0;
            end
            G1: begin
                if (!bus.req[1])
                    nxt = bus.req[0] ? G0 : IDLE;
                else if (bus.req[0] && (cnt == CNT_MAX))
                    nxt = G0;
                else
                    nxt = G1;
            end
            default: nxt = IDLE;
        endcase
    end

    // State plus registered outputs; outputs are decoded from the next state
    // so gnt/S/valid line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= 2'b00;
            s_q     <= 1'b0;
            valid_q <= 1'b0;
            cnt     <= '0;
            last    <= 1'b1;
        end else begin
            state <= nxt;

            case (nxt)
                G0: begin
                    gnt_q   <= 2'b01;
                    s_q     <= 1'b0;
                    valid_q <= 1'b1;
                end
                G1: begin
                    gnt_q   <= 2'b10;
                    s_q     <= 1'b1;
                    valid_q <= 1'b1;
                end
                default: begin
                    // S keeps its last value so the mux output stays put while idle.
                    gnt_q   <= 2'b00;
                    valid_q <= 1'b0;
                end
            endcase

            // Counter restarts on any grant entry and in IDLE; saturates while held.
            if ((nxt != state) || (nxt == IDLE))
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if ((nxt != state) && (nxt != IDLE))
                last <= (nxt == G1);
        end
    end

endmodule

// File: tb/tb_arbitro_rr_mux2x1.sv
module tb_arbitro_rr_mux2x1;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       i0;
    logic       i1;

    int n_checks = 0;
    int n_fail   = 0;

    arbitro_rr_mux2x1_if if8 ();
    arbitro_rr_mux2x1_if if4 ();
    arbitro_rr_mux2x1_if if1 ();

    assign if8.req = req;
    assign if4.req = req;
    assign if1.req = req;

    arbitro_rr_mux2x1 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    arbitro_rr_mux2x1 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    arbitro_rr_mux2x1 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // 2:1 datapath mux fed by the MAX_HOLD=8 arbiter.
    wire y8 = if8.S ? i1 : i0;

    logic [1:0] g_obs [3];
    logic       s_obs [3];
    logic       v_obs [3];
    assign g_obs[0] = if8.gnt;  assign s_obs[0] = if8.S;  assign v_obs[0] = if8.valid;
    assign g_obs[1] = if4.gnt;  assign s_obs[1] = if4.S;  assign v_obs[1] = if4.valid;
    assign g_obs[2] = if1.gnt;  assign s_obs[2] = if1.S;  assign v_obs[2] = if1.valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), cycles granted so far,
    // last served index and the select value the mux should see.
    int mh   [3] = '{8, 4, 1};
    int own  [3];
    int held [3];
    int lst  [3];
    int sexp [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            own[k] = -1; held[k] = 0; lst[k] = 1; sexp[k] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] r);
        for (int k = 0; k < 3; k++) begin
            int o;
            int nx;
            int oth;
            o = own[k];
            if (o < 0) begin
                if (r == 2'b00)      nx = -1;
                else if (r == 2'b01) nx = 0;
                else if (r == 2'b10) nx = 1;
                else                 nx = (lst[k] == 1) ? 0 : 1;
            end else begin
                oth = 1 - o;
                if (!r[o])                              nx = r[oth] ? oth : -1;
                else if (r[oth] && held[k] >= mh[k])    nx = oth;
                else                                    nx = o;
            end
            if (nx < 0) held[k] = 0;
            else if (nx != o) begin held[k] = 1; lst[k] = nx; end
            else held[k] = held[k] + 1;
            own[k] = nx;
            if (nx >= 0) sexp[k] = nx;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            logic [1:0] eg;
            eg = (own[k] == 0) ? 2'b01 : (own[k] == 1) ? 2'b10 : 2'b00;
            chk($sformatf("gnt[mh=%0d]", mh[k]), g_obs[k], eg);
            chk($sformatf("S[mh=%0d]", mh[k]), {1'b0, s_obs[k]}, 2'(sexp[k]));
            chk($sformatf("valid[mh=%0d]", mh[k]), {1'b0, v_obs[k]}, {1'b0, own[k] >= 0});
        end
    endtask

    // Drive req, take one edge, then compare all three arbiters at the falling edge.
    task automatic cycle(input logic [1:0] r);
        req = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        else       model_reset();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        for (int i = 0; i < n; i++) cycle(2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 2'b00;
        i0    = 1'b1;
        i1    = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held for three cycles.
        do_reset(3);
        chk("reset_gnt", if8.gnt, 2'b00);
        chk("reset_S", {1'b0, if8.S}, 2'b00);
        chk("reset_valid", {1'b0, if8.valid}, 2'b00);

        // Single requester on i0, then release.
        cycle(2'b01);
        chk("single_gnt", if8.gnt, 2'b01);
        chk("single_S", {1'b0, if8.S}, 2'b00);
        chk("single_valid", {1'b0, if8.valid}, 2'b01);
        for (int i = 0; i < 4; i++) cycle(2'b01);
        cycle(2'b00);
        chk("drop_gnt", if8.gnt, 2'b00);
        chk("drop_S", {1'b0, if8.S}, 2'b00);
        chk("drop_valid", {1'b0, if8.valid}, 2'b00);

        // Tie from reset: source 0 first, then alternate every MAX_HOLD cycles.
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            cycle(2'b11);
            chk("tie_mh8", if8.gnt, ((i / 8) % 2 == 0) ? 2'b01 : 2'b10);
            chk("tie_mh4", if4.gnt, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
            chk("tie_mh1", if1.gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("tie_S8", {1'b0, if8.S}, {1'b0, (i / 8) % 2 == 1});
        end

        // Handover from G0 to G1 with no idle cycle.
        do_reset(1);
        cycle(2'b11);
        cycle(2'b11);
        chk("hand_pre_gnt", if8.gnt, 2'b01);
        cycle(2'b10);
        chk("hand_gnt", if8.gnt, 2'b10);
        chk("hand_S", {1'b0, if8.S}, 2'b01);
        chk("hand_valid", {1'b0, if8.valid}, 2'b01);

        // Uncontended source is never preempted.
        for (int i = 0; i < 20; i++) begin
            cycle(2'b10);
            chk("nopre_mh4", if4.gnt, 2'b10);
        end

        // Random requests through the mux.
        do_reset(1);
        for (int i = 0; i < 200; i++) begin
            cycle(2'($urandom_range(0, 3)));
            n_checks++;
            assert (if8.gnt !== 2'b11) else begin
                n_fail++;
                $error("FAIL gnt_onehot observed=%b expected=not 11", if8.gnt);
            end
            chk("mux_y", {1'b0, y8}, {1'b0, (sexp[0] == 0) ? i0 : i1});
        end

        // Asynchronous reset in the middle of a G1 grant.
        do_reset(1);
        cycle(2'b10);
        chk("pre_async_gnt", if8.gnt, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_gnt8", if8.gnt, 2'b00);
        chk("async_S8", {1'b0, if8.S}, 2'b00);
        chk("async_valid8", {1'b0, if8.valid}, 2'b00);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'b11);
        chk("tie_after_async", if8.gnt, 2'b01);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
